// File: rtl/ipdc_pkg.sv
// Shared definitions for the image display window block: op codes, FSM states and colour modes.
package ipdc_pkg;

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_RIGHT  = 3'd1;
  localparam logic [2:0] OP_DOWN   = 3'd2;
  localparam logic [2:0] OP_LEFT   = 3'd3;
  localparam logic [2:0] OP_UP     = 3'd4;
  localparam logic [2:0] OP_SHRINK = 3'd5;
  localparam logic [2:0] OP_GROW   = 3'd6;
  localparam logic [2:0] OP_YCBCR  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_UPDATE,
    S_DISPLAY
  } state_t;

  typedef enum logic {
    CM_RGB,
    CM_YCBCR
  } color_mode_t;

endpackage

// File: rtl/ipdc_buf.sv
// Image buffer: one write port and one synchronous read port, one pixel per word.
module ipdc_buf #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing every word would defeat RAM inference, and stale contents are harmless.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ipdc_win.sv
// Image display window: loads a raster image, then moves/scales a square window and streams it out.
// Optional YCbCr output conversion is enabled by defining IPDC_YCBCR_EN.
module ipdc_win
  import ipdc_pkg::*;
#(
  parameter int IMG_W   = 16,
  parameter int IMG_H   = 16,
  parameter int PIX_W   = 8,
  parameter int WIN_MAX = 4,
  parameter int WIN_MIN = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_op_valid,
  input  logic [2:0]         i_op_mode,
  output logic               o_op_ready,
  input  logic               i_in_valid,
  input  logic [3*PIX_W-1:0] i_in_data,
  output logic               o_in_ready,
  output logic               o_out_valid,
  output logic [3*PIX_W-1:0] o_out_data
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int AW    = $clog2(NPIX);
  localparam int LOG_W = $clog2(IMG_W);
  localparam int CW    = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H) + 2;
  localparam int DW    = 3 * PIX_W;

  state_t          state, state_nx;
  logic            alive;
  logic            op_acc, wr_en, last_wr, rd_en, rd_vld_q;
  logic [2:0]      op_q;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [CW-1:0]   x_q, y_q, size_q, x_nx, y_nx, size_nx;
  logic [CW-1:0]   win_x, win_y, win_s, col, row, px, py;
  logic [DW-1:0]   rd_data, pix_out;

  assign o_op_ready = alive && (state == S_IDLE);
  assign o_in_ready = (state == S_LOAD);
  assign op_acc     = i_op_valid && o_op_ready;
  assign wr_en      = (state == S_LOAD) && i_in_valid;
  assign last_wr    = (wr_addr == AW'(NPIX - 1));

  // Pixel 0 is fetched during UPDATE using the new geometry, which saves a cycle of latency.
  assign win_x   = (state == S_UPDATE) ? x_nx    : x_q;
  assign win_y   = (state == S_UPDATE) ? y_nx    : y_q;
  assign win_s   = (state == S_UPDATE) ? size_nx : size_q;
  assign rd_en   = (state == S_UPDATE) || ((state == S_DISPLAY) && (row < size_q));
  assign px      = win_x + col;
  assign py      = win_y + row;
  assign rd_addr = (AW'(py) << LOG_W) | AW'(px);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    x_nx    = x_q;
    y_nx    = y_q;
    size_nx = size_q;
    case (op_q)
      OP_RIGHT:  if (x_q + size_q < CW'(IMG_W)) x_nx = x_q + CW'(1);
      OP_DOWN:   if (y_q + size_q < CW'(IMG_H)) y_nx = y_q + CW'(1);
      OP_LEFT:   if (x_q != '0) x_nx = x_q - CW'(1);
      OP_UP:     if (y_q != '0) y_nx = y_q - CW'(1);
      OP_SHRINK: if (size_q > CW'(WIN_MIN)) size_nx = size_q >> 1;
      OP_GROW:   if ((size_q < CW'(WIN_MAX)) && (x_q + (size_q << 1) <= CW'(IMG_W)) &&
                     (y_q + (size_q << 1) <= CW'(IMG_H))) size_nx = size_q << 1;
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (op_acc) state_nx = (i_op_mode == OP_LOAD) ? S_LOAD : S_UPDATE;
      S_LOAD:    if (wr_en && last_wr) state_nx = S_DISPLAY;
      S_UPDATE:  state_nx = S_DISPLAY;
      S_DISPLAY: if ((row == size_q) && !rd_vld_q) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alive       <= 1'b0;
      op_q        <= OP_LOAD;
      wr_addr     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      size_q      <= CW'(WIN_MAX);
      col         <= '0;
      row         <= '0;
      rd_vld_q    <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
    end else begin
      alive <= 1'b1;
      if (op_acc) op_q <= i_op_mode;
      if (op_acc && (i_op_mode == OP_LOAD)) wr_addr <= '0;
      else if (wr_en)                       wr_addr <= wr_addr + AW'(1);
      if (wr_en && last_wr) begin
        x_q    <= '0;
        y_q    <= '0;
        size_q <= CW'(WIN_MAX);
      end else if (state == S_UPDATE) begin
        x_q    <= x_nx;
        y_q    <= y_nx;
        size_q <= size_nx;
      end
      if ((state == S_IDLE) || (state == S_LOAD)) begin
        col <= '0;
        row <= '0;
      end else if (rd_en) begin
        if (col == win_s - CW'(1)) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      rd_vld_q    <= rd_en;
      o_out_valid <= rd_vld_q;
      o_out_data  <= rd_vld_q ? pix_out : '0;
    end
  end

`ifdef IPDC_YCBCR_EN
  localparam int SW = PIX_W + 5;
  localparam logic signed [SW-1:0] KOFS = SW'((1 << (PIX_W + 2)) + 4);
  localparam logic signed [SW-1:0] PMAX = SW'((1 << PIX_W) - 1);

  color_mode_t mode_q;

  function automatic logic [PIX_W-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] s;
    s = v >>> 3;
    if (s[SW-1]) return '0;
    if (s > PMAX) return '1;
    return s[PIX_W-1:0];
  endfunction

  function automatic logic [DW-1:0] to_ycbcr(input logic [DW-1:0] p);
    logic signed [SW-1:0] r, g, b, yv, cb, cr;
    r  = $signed({{(SW - PIX_W){1'b0}}, p[3*PIX_W-1 -: PIX_W]});
    g  = $signed({{(SW - PIX_W){1'b0}}, p[2*PIX_W-1 -: PIX_W]});
    b  = $signed({{(SW - PIX_W){1'b0}}, p[PIX_W-1:0]});
    yv = (r <<< 1) + (g <<< 2) + g + SW'(4);
    cb = (b <<< 2) - r - (g <<< 1) + KOFS;
    cr = (r <<< 2) - (g <<< 1) - g - b + KOFS;
    return {sat(yv), sat(cb), sat(cr)};
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mode_q <= CM_RGB;
    else if ((state == S_UPDATE) && (op_q == OP_YCBCR))
      mode_q <= (mode_q == CM_RGB) ? CM_YCBCR : CM_RGB;
  end

  assign pix_out = (mode_q == CM_YCBCR) ? to_ycbcr(rd_data) : rd_data;
`else
  assign pix_out = rd_data;
`endif

  ipdc_buf #(
    .DEPTH (NPIX),
    .WIDTH (DW),
    .AW    (AW)
  ) u_buf (
    .clk     (i_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (i_in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_ipdc_win.sv
// Directed self-checking bench for ipdc_win: load, moves, scaling, colour toggle and reset abort.
module tb_ipdc_win;
  import ipdc_pkg::*;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_mode = 3'd0;
  logic        op_ready;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_data;

  int          n_pass = 0;
  int          n_total = 0;
  logic [23:0] got [16];

  ipdc_win #(
    .IMG_W(16), .IMG_H(16), .PIX_W(8), .WIN_MAX(4), .WIN_MIN(1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_op_valid  (op_valid),
    .i_op_mode   (op_mode),
    .o_op_ready  (op_ready),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] pix(input int i, input bit special);
    logic [7:0] v;
    v = 8'(i);
    if (special && i == 0) return {8'd100, 8'd200, 8'd50};
    return {v, v, v};
  endfunction

  // Wait for ready, present the op for one cycle; returns at the falling edge after the accepting edge.
  task automatic send_op(input logic [2:0] m);
    int k = 0;
    while (op_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("op_ready_wait", op_ready, 1);
    op_valid = 1'b1;
    op_mode  = m;
    @(negedge clk);
    op_valid = 1'b0;
    op_mode  = 3'd0;
  endtask

  // Expect first valid two cycles after the accepting edge, n back-to-back pixels, then idle.
  task automatic collect(input string tag, input int n);
    int lat = 0;
    int gaps = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (out_valid !== 1'b1) gaps++;
      got[k] = out_data;
    end
    check({tag, "_gaps"}, gaps, 0);
    @(negedge clk);
    check({tag, "_tail_valid"}, out_valid, 0);
    check({tag, "_tail_data"}, out_data, 0);
    check({tag, "_ready_back"}, op_ready, 1);
  endtask

  task automatic run_op(input logic [2:0] m, input int n, input string tag);
    send_op(m);
    collect(tag, n);
  endtask

  task automatic check_win(input string tag, input int x, input int y, input int s);
    for (int k = 0; k < s * s; k++)
      check($sformatf("%s_px%0d", tag, k), got[k], pix((y + k / s) * W + x + k % s, 1'b0));
  endtask

  // Gapped loads also hold a stray op request, which must be ignored outside IDLE.
  task automatic load(input string tag, input bit gap, input bit special);
    send_op(OP_LOAD);
    check({tag, "_in_ready"}, in_ready, 1);
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = pix(i, special);
      if (gap) begin
        op_valid = 1'b1;
        op_mode  = OP_DOWN;
      end
      @(negedge clk);
      if (gap && i < 255) begin
        in_valid = 1'b0;
        in_data  = 24'hA5A5A5;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
    op_valid = 1'b0;
    op_mode  = 3'd0;
    collect(tag, 16);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_op_ready", op_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1 check("release_op_ready_low", op_ready, 0);
    @(negedge clk);
    check("release_op_ready_high", op_ready, 1);

    load("load_gap", 1'b1, 1'b0);
    check_win("load_gap", 0, 0, 4);
    load("load_nogap", 0, 0);
    check_win("load_nogap", 0, 0, 4);

    // Stray pixels in IDLE must not reach the buffer.
    in_valid = 1'b1;
    in_data  = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;
    in_data  = '0;
    run_op(OP_LEFT, 16, "left_reject");
    check_win("left_reject", 0, 0, 4);
    run_op(OP_UP, 16, "up_reject");
    check_win("up_reject", 0, 0, 4);

    for (int i = 0; i < 12; i++) run_op(OP_RIGHT, 16, "right");
    check_win("right12", 12, 0, 4);
    run_op(OP_RIGHT, 16, "right13");
    check_win("right13", 12, 0, 4);

    run_op(OP_SHRINK, 4, "shrink_a");
    check_win("shrink_a", 12, 0, 2);
    run_op(OP_SHRINK, 1, "shrink_b");
    check_win("shrink_b", 12, 0, 1);
    run_op(OP_SHRINK, 1, "shrink_min");
    check_win("shrink_min", 12, 0, 1);
    run_op(OP_GROW, 4, "grow_ok");
    check_win("grow_ok", 12, 0, 2);
    run_op(OP_RIGHT, 4, "right_s2a");
    run_op(OP_RIGHT, 4, "right_s2b");
    check_win("right_s2b", 14, 0, 2);
    run_op(OP_GROW, 4, "grow_reject");
    check_win("grow_reject", 14, 0, 2);
    run_op(OP_DOWN, 4, "down");
    check_win("down", 14, 1, 2);

`ifdef IPDC_YCBCR_EN
    load("load_color", 1'b0, 1'b1);
    check("color_rgb_px0", got[0], {8'd100, 8'd200, 8'd50});
    run_op(OP_YCBCR, 16, "ycbcr_on");
    check("ycbcr_px0", got[0], {8'd150, 8'd91, 8'd97});
    check("ycbcr_px1", got[1], {8'd1, 8'd128, 8'd128});
    run_op(OP_YCBCR, 16, "ycbcr_off");
    check("ycbcr_off_px0", got[0], {8'd100, 8'd200, 8'd50});
`else
    run_op(OP_YCBCR, 4, "op7_noop");
    check_win("op7_noop", 14, 1, 2);
`endif

    // Abort a display with reset at its third pixel.
    begin
      int lat = 0;
      send_op(OP_LEFT);
      while (out_valid !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      repeat (2) @(negedge clk);
      check("abort_third_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_out_data", out_data, 0);
      check("abort_op_ready", op_ready, 0);
      @(negedge clk);
      check("abort_hold_valid", out_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_release_ready", op_ready, 1);
      check("abort_release_valid", out_valid, 0);
    end
    run_op(OP_LEFT, 16, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
